pulse_capture: RTL and testbench
================================

PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 Parameter PERIOD, default 20000, SHALL be the window length in clk cycles (1 ms at 20 MHz).
REQ-002 Parameter FILT, default 4, SHALL be the minimum pulse_in high time, in clk cycles, for a pulse to count.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 pulse_in  input  1  step pulse from the axis pulse generator; asynchronous to clk.
REQ-006 dir_in  input  1  direction from the axis pulse generator; 0 = forward, 1 = reverse; asynchronous.
REQ-007 RD  input  1  MCU read strobe; a rising edge requests a read.
REQ-008 SEL  input  2  read select: 0 = window word, 1 = position[7:0], 2 = position[15:8], 3 = status.
REQ-009 Q  output  8  read data; holds its value between reads.
REQ-010 valid  output  1  a new window word is latched and unread.
REQ-011 ovf  output  1  sticky flag: a window word was overwritten before it was read.

Function
REQ-012 pulse_in, dir_in and RD SHALL each pass through a 2-flop synchronizer; pulse_s, dir_s and rd_s denote the second stages.
REQ-013 A high-run counter SHALL count consecutive cycles with pulse_s=1, saturate at FILT, and clear to 0 in any cycle with pulse_s=0.
REQ-014 A step event SHALL fire exactly once per high run, in the cycle the high-run counter reaches FILT; shorter runs SHALL be ignored.
REQ-015 Direction of a step event SHALL be dir_s in the step-event cycle.
REQ-016 Position (16-bit) SHALL increment on a forward step event and decrement on a reverse one, wrapping modulo 2^16 in both directions.
REQ-017 Window accumulator (signed, 8-bit range) SHALL add +1 for a forward step and -1 for a reverse step, saturating at +127 and -127.
REQ-018 Window counter SHALL count 0..PERIOD-1 and wrap; the cycle at PERIOD-1 is the window end.
REQ-019 At window end the accumulator SHALL be latched into the window word in sign-magnitude form: bit7 = 1 if negative, bits[6:0] = |value|; the accumulator SHALL then clear.
REQ-020 A step event in the window-end cycle SHALL count toward the next window (accumulator := ±1), SHALL be excluded from the latched word, and SHALL still update position.
REQ-021 valid SHALL set at window end.
REQ-022 If valid is already 1 at window end, ovf SHALL set, and the new word SHALL replace the old one.
REQ-023 A read event SHALL be a rising edge of rd_s (rd_s=1 while its previous value was 0).
REQ-024 One cycle after a read event, Q SHALL load: SEL=0 window word; SEL=1 position[7:0]; SEL=2 the high-byte snapshot; SEL=3 {6'b0, ovf, valid}.
REQ-025 A read with SEL=1 SHALL capture position[15:8] into a high-byte snapshot in the same cycle, so that a following SEL=2 read returns a coherent 16-bit pair.
REQ-026 A read with SEL=0 SHALL clear valid and ovf; if a window end occurs in the same cycle, the set SHALL win.
REQ-027 Reads with SEL=1, 2 or 3 SHALL NOT alter valid or ovf.
REQ-028 Latency from the pulse_in rising edge to the position update SHALL be 2 + FILT clk cycles.

Reset
REQ-029 When rst_n=0, Q, valid, ovf, position, the high-byte snapshot, window word, accumulator, window counter, high-run counter and all synchronizer flops SHALL clear to 0 immediately.
REQ-030 Reset mid-window SHALL discard partial counts; after release, the first window end SHALL occur PERIOD cycles later.

Verification
REQ-031 Ten forward pulses of 200 cycles high / 200 cycles low within one window, then RD with SEL=0 -> Q=0x0A, valid=1 before the read and 0 after, ovf=0.
REQ-032 Five reverse pulses, then RD with SEL=0 -> Q=0x85; position=0xFFFB; reads with SEL=1 then SEL=2 -> 0xFB then 0xFF.
REQ-033 Pulses 3 cycles high (FILT=4) -> no count change; a pulse exactly 4 cycles high -> position +1, 6 cycles after the pulse_in rising edge.
REQ-034 200 forward steps in one window (short PERIOD) -> Q=0x7F; two windows with no read -> ovf=1; a read with SEL=3 -> Q=0x03.
REQ-035 Step event forced at window end -> latched word excludes it, next window word counts it, position includes it.
REQ-036 Assert rst_n mid-window with valid=1 -> all outputs 0 at once; after release the next window end occurs PERIOD cycles later.

Source files
------------

// File: rtl/pulse_capture.sv
// Step/direction capture for one axis: filters the step pulses, tracks a 16-bit position,
// and latches a per-window signed step count that an MCU reads one byte at a time.
module pulse_capture #(
  parameter int PERIOD = 20000,
  parameter int FILT   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse_in,
  input  logic       dir_in,
  input  logic       RD,
  input  logic [1:0] SEL,
  output logic [7:0] Q,
  output logic       valid,
  output logic       ovf
);

  localparam int HW = $clog2(FILT + 1);
  localparam int WW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  // One step towards the current direction, clamped to the symmetric +/-127 range.
  function automatic logic signed [7:0] sat_step(input logic signed [7:0] a,
                                                 input logic rev);
    if (rev) return (a == -8'sd127) ? a : a - 8'sd1;
    else     return (a ==  8'sd127) ? a : a + 8'sd1;
  endfunction

  function automatic logic [7:0] sign_mag(input logic signed [7:0] a);
    logic signed [7:0] neg;
    neg = -a;
    return a[7] ? {1'b1, neg[6:0]} : {1'b0, a[6:0]};
  endfunction

  logic [1:0]        r_pulse_sync;
  logic [1:0]        r_dir_sync;
  logic [1:0]        r_rd_sync;
  logic              r_rd_prev;
  logic [HW-1:0]     r_hi_cnt;
  logic [15:0]       r_pos;
  logic [7:0]        r_snap;
  logic signed [7:0] r_acc;
  logic [7:0]        r_word;
  logic [WW-1:0]     r_win_cnt;
  logic              r_valid;
  logic              r_ovf;
  logic [7:0]        r_q;

  logic w_pulse_s;
  logic w_dir_s;
  logic w_rd_s;
  logic w_step;
  logic w_win_end;
  logic w_rd_evt;

  assign w_pulse_s = r_pulse_sync[1];
  assign w_dir_s   = r_dir_sync[1];
  assign w_rd_s    = r_rd_sync[1];
  // The step fires on the single cycle the run counter climbs into FILT.
  assign w_step    = w_pulse_s && (r_hi_cnt == HW'(FILT - 1));
  assign w_win_end = (r_win_cnt == WW'(PERIOD - 1));
  assign w_rd_evt  = w_rd_s && !r_rd_prev;

  assign Q     = r_q;
  assign valid = r_valid;
  assign ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_sync <= '0;
      r_dir_sync   <= '0;
      r_rd_sync    <= '0;
      r_rd_prev    <= 1'b0;
    end else begin
      r_pulse_sync <= {r_pulse_sync[0], pulse_in};
      r_dir_sync   <= {r_dir_sync[0], dir_in};
      r_rd_sync    <= {r_rd_sync[0], RD};
      r_rd_prev    <= w_rd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_cnt <= '0;
    end else if (!w_pulse_s) begin
      r_hi_cnt <= '0;
    end else if (r_hi_cnt != HW'(FILT)) begin
      r_hi_cnt <= r_hi_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
    end else if (w_step) begin
      r_pos <= w_dir_s ? r_pos - 16'd1 : r_pos + 16'd1;
    end
  end

  // A step landing on the window-end cycle seeds the next window instead of this one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_acc     <= '0;
      r_word    <= '0;
    end else if (w_win_end) begin
      r_win_cnt <= '0;
      r_word    <= sign_mag(r_acc);
      r_acc     <= w_step ? (w_dir_s ? -8'sd1 : 8'sd1) : 8'sd0;
    end else begin
      r_win_cnt <= r_win_cnt + WW'(1);
      if (w_step) r_acc <= sat_step(r_acc, w_dir_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_win_end) begin
      r_valid <= 1'b1;
      if (r_valid) r_ovf <= 1'b1;
    end else if (w_rd_evt && (SEL == 2'd0)) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  // Reading the low byte freezes the high byte so the pair stays coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_snap <= '0;
    end else if (w_rd_evt) begin
      case (SEL)
        2'd0:    r_q <= r_word;
        2'd1:    r_q <= r_pos[7:0];
        2'd2:    r_q <= r_snap;
        default: r_q <= {6'b0, r_ovf, r_valid};
      endcase
      if (SEL == 2'd1) r_snap <= r_pos[15:8];
    end
  end

endmodule

// File: tb/tb_pulse_capture.sv
// Bench for pulse_capture: directed scenarios plus a randomized run, all checked against
// a history-based reference model of the capture rules.
module tb_pulse_capture;

  localparam int P = 5000;
  localparam int F = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse_in, dir_in, RD;
  logic [1:0] SEL;
  logic [7:0] Q;
  logic       valid, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_capture #(.PERIOD(P), .FILT(F)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .dir_in(dir_in),
    .RD(RD), .SEL(SEL), .Q(Q), .valid(valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: input history per edge; a step is a run of exactly F highs seen
  // through a two-cycle delay, a read is a 0->1 of RD seen through the same delay.
  logic [F+1:0] mh_p;
  logic [1:0]   mh_d;
  logic [2:0]   mh_r;
  int           m_edge, m_acc, m_delta;
  logic [15:0]  m_pos;
  logic [7:0]   m_word, m_q, m_snap;
  logic         m_valid, m_ovf, m_step, m_win, m_rdev;

  function automatic int clamp127(input int v);
    return (v > 127) ? 127 : ((v < -127) ? -127 : v);
  endfunction

  function automatic logic [7:0] sm_of(input int v);
    return (v < 0) ? {1'b1, 7'(-v)} : {1'b0, 7'(v)};
  endfunction

  always_comb begin
    m_step  = (&mh_p[F:1]) && !mh_p[F+1];
    m_delta = !m_step ? 0 : (mh_d[1] ? -1 : 1);
    m_win   = ((m_edge + 1) % P) == 0;
    m_rdev  = mh_r[1] && !mh_r[2];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh_p <= '0; mh_d <= '0; mh_r <= '0; m_edge <= 0; m_acc <= 0;
      m_pos <= '0; m_word <= '0; m_q <= '0; m_snap <= '0; m_valid <= 1'b0; m_ovf <= 1'b0;
    end else begin
      mh_p   <= {mh_p[F:0], pulse_in};
      mh_d   <= {mh_d[0], dir_in};
      mh_r   <= {mh_r[1:0], RD};
      m_edge <= m_edge + 1;
      m_pos  <= m_pos + 16'(m_delta);
      if (m_win) begin
        m_word  <= sm_of(m_acc);
        m_acc   <= m_delta;
        m_valid <= 1'b1;
        if (m_valid) m_ovf <= 1'b1;
      end else begin
        m_acc <= clamp127(m_acc + m_delta);
        if (m_rdev && SEL == 2'd0) begin
          m_valid <= 1'b0;
          m_ovf   <= 1'b0;
        end
      end
      if (m_rdev) begin
        case (SEL)
          2'd0: m_q <= m_word;
          2'd1: m_q <= m_pos[7:0];
          2'd2: m_q <= m_snap;
          default: m_q <= {6'b0, m_ovf, m_valid};
        endcase
        if (SEL == 2'd1) m_snap <= m_pos[15:8];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; pulse_in = 1'b0; dir_in = 1'b0; RD = 1'b0; SEL = 2'd0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int hi, input int lo, input logic d);
    dir_in = d; pulse_in = 1'b1;
    tick(hi);
    pulse_in = 1'b0;
    tick(lo);
  endtask

  task automatic do_read(input logic [1:0] s);
    SEL = s; RD = 1'b1;
    tick(3);
    RD = 1'b0;
    tick(3);
  endtask

  task automatic wait_win();
    int n = 0;
    do begin tick(1); n++; end while ((m_edge % P) != 0 && n < P + 4);
    if ((m_edge % P) != 0) begin
      n_fail++;
      $display("FAIL wait_win: no window end within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse_in = 1'b0; dir_in = 1'b0; RD = 1'b0; SEL = 2'd0;
    tick(3);
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", Q); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst_n = 1'b1;
    tick(1);
    do_read(2'd1);
    n_checks++; if (Q !== 8'h00 || Q !== m_q) begin n_fail++; $display("FAIL reset_pos: got %h want 00 model %h", Q, m_q); end
  endtask

  task automatic test_forward();
    apply_reset();
    for (int i = 0; i < 10; i++) pulse(200, 200, 1'b0);
    wait_win();
    n_checks++; if (valid !== 1'b1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid_set: got %b want 1", valid); end
    do_read(2'd0);
    n_checks++; if (Q !== 8'h0A || Q !== m_q) begin n_fail++; $display("FAIL fwd_word: got %h want 0a model %h", Q, m_q); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fwd_valid_clr: got %b want 0", valid); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fwd_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_reverse();
    apply_reset();
    tick(2);
    for (int i = 0; i < 5; i++) pulse(200, 200, 1'b1);
    wait_win();
    do_read(2'd0);
    n_checks++; if (Q !== 8'h85 || Q !== m_q) begin n_fail++; $display("FAIL rev_word: got %h want 85 model %h", Q, m_q); end
    do_read(2'd1);
    n_checks++; if (Q !== 8'hFB || Q !== m_q) begin n_fail++; $display("FAIL rev_pos_lo: got %h want fb model %h", Q, m_q); end
    do_read(2'd2);
    n_checks++; if (Q !== 8'hFF || Q !== m_q) begin n_fail++; $display("FAIL rev_pos_hi: got %h want ff model %h", Q, m_q); end
  endtask

  task automatic test_filter();
    logic [15:0] p0;
    apply_reset();
    tick(2);
    for (int i = 0; i < 3; i++) pulse(3, 10, 1'b0);
    do_read(2'd1);
    n_checks++; if (Q !== 8'h00 || Q !== m_q) begin n_fail++; $display("FAIL filt_short: got %h want 00 model %h", Q, m_q); end
    p0 = m_pos;
    pulse_in = 1'b1;
    tick(4);
    pulse_in = 1'b0;
    tick(1);
    n_checks++; if (dut.r_pos !== p0) begin n_fail++; $display("FAIL filt_early: got %h want %h", dut.r_pos, p0); end
    tick(1);
    n_checks++; if (dut.r_pos !== p0 + 16'd1) begin n_fail++; $display("FAIL filt_latency: got %h want %h", dut.r_pos, p0 + 16'd1); end
    tick(4);
    do_read(2'd1);
    n_checks++; if (Q !== 8'h01 || Q !== m_q) begin n_fail++; $display("FAIL filt_exact: got %h want 01 model %h", Q, m_q); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 200; i++) pulse(5, 5, 1'b0);
    wait_win();
    for (int i = 0; i < 200; i++) pulse(5, 5, 1'b0);
    wait_win();
    n_checks++; if (ovf !== 1'b1 || m_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", ovf); end
    do_read(2'd3);
    n_checks++; if (Q !== 8'h03 || Q !== m_q) begin n_fail++; $display("FAIL sat_status: got %h want 03 model %h", Q, m_q); end
    do_read(2'd0);
    n_checks++; if (Q !== 8'h7F || Q !== m_q) begin n_fail++; $display("FAIL sat_word: got %h want 7f model %h", Q, m_q); end
    n_checks++; if (ovf !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got ovf=%b valid=%b want 0 0", ovf, valid); end
  endtask

  task automatic test_window_end_step();
    int n = 0;
    apply_reset();
    tick(2);
    for (int i = 0; i < 3; i++) pulse(20, 20, 1'b0);
    while (m_edge != P - 6 && n < 2 * P) begin tick(1); n++; end
    pulse_in = 1'b1;
    tick(4);
    pulse_in = 1'b0;
    tick(2);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL we_valid: got %b want 1", valid); end
    do_read(2'd0);
    n_checks++; if (Q !== 8'h03 || Q !== m_q) begin n_fail++; $display("FAIL we_word_excl: got %h want 03 model %h", Q, m_q); end
    wait_win();
    do_read(2'd0);
    n_checks++; if (Q !== 8'h01 || Q !== m_q) begin n_fail++; $display("FAIL we_word_next: got %h want 01 model %h", Q, m_q); end
    do_read(2'd1);
    n_checks++; if (Q !== 8'h04 || Q !== m_q) begin n_fail++; $display("FAIL we_pos: got %h want 04 model %h", Q, m_q); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    tick(2);
    for (int i = 0; i < 2; i++) pulse(20, 20, 1'b0);
    wait_win();
    tick(100);
    do_read(2'd1);
    n_checks++; if (valid !== 1'b1 || Q !== 8'h02) begin n_fail++; $display("FAIL rm_pre: got valid=%b q=%h want 1 02", valid, Q); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (Q !== 8'h00 || valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got q=%h valid=%b ovf=%b want 00 0 0", Q, valid, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    while (n < 2 * P) begin
      tick(1); n++;
      if (valid === 1'b1) break;
    end
    n_checks++; if (n != P || m_valid !== 1'b1) begin n_fail++; $display("FAIL rm_period: got %0d cycles want %0d", n, P); end
  endtask

  task automatic test_random();
    apply_reset();
    tick(2);
    while (m_edge < 8000) begin
      if ($urandom_range(0, 4) == 0) begin
        do_read(2'($urandom_range(0, 3)));
        n_checks++; if (Q !== m_q) begin n_fail++; $display("FAIL rnd_q: got %h want %h sel %0d", Q, m_q, SEL); end
        n_checks++; if (valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid: got %b want %b", valid, m_valid); end
        n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf: got %b want %b", ovf, m_ovf); end
      end else begin
        pulse($urandom_range(1, 8), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      end
    end
    do_read(2'd1);
    n_checks++; if (Q !== m_pos[7:0]) begin n_fail++; $display("FAIL rnd_pos_lo: got %h want %h", Q, m_pos[7:0]); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_filter();
    test_saturate();
    test_window_end_step();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
